// File: rtl/dcp_frame_ctrl.sv
`timescale 1ns/1ps
// dcp_frame_ctrl: frame sequencer for the min9x9 dark-channel pipeline.
// Streams one RGB frame into the datapath, pads with all-ones pixels to drain
// the line buffers, and tags the returned dark-channel beats with sof/eol/eof.
module dcp_frame_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int IMG_WIDTH  = 320,
  parameter int IMG_HEIGHT = 240,
  parameter int FLUSH_ROWS = 4
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_start,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_err,
  input  logic                  i_s_valid,
  output logic                  o_s_ready,
  input  logic [DATA_WIDTH-1:0] i_s_r,
  input  logic [DATA_WIDTH-1:0] i_s_g,
  input  logic [DATA_WIDTH-1:0] i_s_b,
  output logic                  o_dp_valid,
  output logic [DATA_WIDTH-1:0] o_dp_r,
  output logic [DATA_WIDTH-1:0] o_dp_g,
  output logic [DATA_WIDTH-1:0] o_dp_b,
  input  logic                  i_dp_valid_out,
  input  logic [DATA_WIDTH-1:0] i_dp_dark,
  output logic                  o_m_valid,
  output logic [DATA_WIDTH-1:0] o_m_dark,
  output logic                  o_m_sof,
  output logic                  o_m_eol,
  output logic                  o_m_eof
);

  localparam int PIX   = IMG_WIDTH * IMG_HEIGHT;
  localparam int CAP   = (FLUSH_ROWS + 1) * IMG_WIDTH;
  localparam int IN_W  = (PIX > 1) ? $clog2(PIX) : 1;
  localparam int OUT_W = $clog2(PIX + 1);
  localparam int PAD_W = $clog2(CAP + 1);
  localparam int COL_W = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;

  localparam logic [IN_W-1:0]  IN_LAST  = IN_W'(PIX - 1);
  localparam logic [OUT_W-1:0] OUT_FULL = OUT_W'(PIX);
  localparam logic [OUT_W-1:0] OUT_LAST = OUT_W'(PIX - 1);
  localparam logic [PAD_W-1:0] PAD_CAP  = PAD_W'(CAP);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_FLUSH = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic w_accept;
  logic w_pad;
  logic w_start_frame;
  logic w_err_set;
  logic w_take;

  logic [IN_W-1:0]       r_in_cnt;
  logic [OUT_W-1:0]      r_out_cnt;
  logic [PAD_W-1:0]      r_pad_cnt;
  logic [COL_W-1:0]      r_col;
  logic                  r_err_flag;
  logic                  r_dp_valid;
  logic [DATA_WIDTH-1:0] r_dp_r;
  logic [DATA_WIDTH-1:0] r_dp_g;
  logic [DATA_WIDTH-1:0] r_dp_b;
  logic                  r_m_valid;
  logic [DATA_WIDTH-1:0] r_m_dark;
  logic                  r_m_sof;
  logic                  r_m_eol;
  logic                  r_m_eof;

  // Returned beats count only inside a frame and only up to a full frame
  assign w_take = i_dp_valid_out && (r_state != S_IDLE) && (r_out_cnt < OUT_FULL);

  // State register
  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next state plus per-cycle accept/pad strobes; completion is tested before the pad cap so it wins a tie
  always_comb begin
    w_state_nxt   = r_state;
    w_accept      = 1'b0;
    w_pad         = 1'b0;
    w_start_frame = 1'b0;
    w_err_set     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_start) begin
          w_state_nxt   = S_RUN;
          w_start_frame = 1'b1;
        end
      end
      S_RUN: begin
        w_accept = i_s_valid;
        if (i_s_valid && (r_in_cnt == IN_LAST)) w_state_nxt = S_FLUSH;
      end
      S_FLUSH: begin
        if (r_out_cnt == OUT_FULL) begin
          w_state_nxt = S_DONE;
        end else if (r_pad_cnt == PAD_CAP) begin
          w_state_nxt = S_DONE;
          w_err_set   = 1'b1;
        end else begin
          w_pad = 1'b1;
        end
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Input-side counters and the drain-failure flag, all cleared when a frame is armed
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_in_cnt   <= '0;
      r_pad_cnt  <= '0;
      r_err_flag <= 1'b0;
    end else if (w_start_frame) begin
      r_in_cnt   <= '0;
      r_pad_cnt  <= '0;
      r_err_flag <= 1'b0;
    end else begin
      if (w_accept)  r_in_cnt   <= r_in_cnt + IN_W'(1);
      if (w_pad)     r_pad_cnt  <= r_pad_cnt + PAD_W'(1);
      if (w_err_set) r_err_flag <= 1'b1;
    end
  end

  // Output-side beat counter and column position used for the frame tags
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_out_cnt <= '0;
      r_col     <= '0;
    end else if (w_start_frame) begin
      r_out_cnt <= '0;
      r_col     <= '0;
    end else if (w_take) begin
      r_out_cnt <= r_out_cnt + OUT_W'(1);
      r_col     <= (r_col == COL_LAST) ? '0 : r_col + COL_W'(1);
    end
  end

  // Registered datapath feed: accepted pixels pass through, pads are all-ones so they never win a min
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_dp_valid <= 1'b0;
      r_dp_r     <= '0;
      r_dp_g     <= '0;
      r_dp_b     <= '0;
    end else begin
      r_dp_valid <= w_accept | w_pad;
      if (w_accept) begin
        r_dp_r <= i_s_r;
        r_dp_g <= i_s_g;
        r_dp_b <= i_s_b;
      end else if (w_pad) begin
        r_dp_r <= '1;
        r_dp_g <= '1;
        r_dp_b <= '1;
      end
    end
  end

  // Registered tagged output stream
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_m_valid <= 1'b0;
      r_m_dark  <= '0;
      r_m_sof   <= 1'b0;
      r_m_eol   <= 1'b0;
      r_m_eof   <= 1'b0;
    end else begin
      r_m_valid <= w_take;
      r_m_sof   <= w_take && (r_out_cnt == '0);
      r_m_eol   <= w_take && (r_col == COL_LAST);
      r_m_eof   <= w_take && (r_out_cnt == OUT_LAST);
      if (w_take) r_m_dark <= i_dp_dark;
    end
  end

  assign o_busy     = (r_state != S_IDLE);
  assign o_done     = (r_state == S_DONE);
  assign o_err      = (r_state == S_DONE) && r_err_flag;
  assign o_s_ready  = (r_state == S_RUN);
  assign o_dp_valid = r_dp_valid;
  assign o_dp_r     = r_dp_r;
  assign o_dp_g     = r_dp_g;
  assign o_dp_b     = r_dp_b;
  assign o_m_valid  = r_m_valid;
  assign o_m_dark   = r_m_dark;
  assign o_m_sof    = r_m_sof;
  assign o_m_eol    = r_m_eol;
  assign o_m_eof    = r_m_eof;

endmodule

// File: tb/tb_dcp_frame_ctrl.sv
`timescale 1ns/1ps
// tb_dcp_frame_ctrl: directed bench for dcp_frame_ctrl (W=8, H=6, FLUSH_ROWS=4).
// A beat-indexed stand-in replaces min9x9: input beat n releases output beat
// n-stubLag carrying min(r,g,b) of that earlier beat, like a line-buffered window.
module tb_dcp_frame_ctrl;

  localparam int DW   = 8;
  localparam int W    = 8;
  localparam int H    = 6;
  localparam int NPIX = W * H;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          sValid;
  logic [DW-1:0] sR, sG, sB;
  logic          busy, done, err, sReady;
  logic          dpValid;
  logic [DW-1:0] dpR, dpG, dpB;
  logic          dpValidOut;
  logic [DW-1:0] dpDark;
  logic          mValid;
  logic [DW-1:0] mDark;
  logic          mSof, mEol, mEof;

  int testsRun  = 0;
  int failCount = 0;

  int            stubLag   = 36;
  int            stubLimit = 1000;
  int            stubIn    = 0;
  int            stubOut   = 0;
  int            stubBack;
  logic          stubClear = 1'b1;
  logic          stubValid = 1'b0;
  logic [DW-1:0] stubDark  = '0;
  logic [DW-1:0] stubMem [0:255];
  logic          manual    = 1'b0;
  logic          manValid  = 1'b0;

  logic [10:0] beatLog[$];
  logic [23:0] pixLog[$];
  int padCnt    = 0;
  int doneCnt   = 0;
  int errCnt    = 0;
  int errNoDone = 0;

  dcp_frame_ctrl #(
    .DATA_WIDTH(DW),
    .IMG_WIDTH (W),
    .IMG_HEIGHT(H),
    .FLUSH_ROWS(4)
  ) dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_start       (start),
    .o_busy        (busy),
    .o_done        (done),
    .o_err         (err),
    .i_s_valid     (sValid),
    .o_s_ready     (sReady),
    .i_s_r         (sR),
    .i_s_g         (sG),
    .i_s_b         (sB),
    .o_dp_valid    (dpValid),
    .o_dp_r        (dpR),
    .o_dp_g        (dpG),
    .o_dp_b        (dpB),
    .i_dp_valid_out(dpValidOut),
    .i_dp_dark     (dpDark),
    .o_m_valid     (mValid),
    .o_m_dark      (mDark),
    .o_m_sof       (mSof),
    .o_m_eol       (mEol),
    .o_m_eof       (mEof)
  );

  always #5 clk = ~clk;

  assign dpValidOut = manual ? manValid : stubValid;
  assign dpDark     = manual ? 8'hAA    : stubDark;

  function automatic logic [DW-1:0] min3(input logic [DW-1:0] a, input logic [DW-1:0] b, input logic [DW-1:0] c);
    logic [DW-1:0] m;
    m = (a < b) ? a : b;
    return (m < c) ? m : c;
  endfunction

  function automatic logic [10:0] expTag(input int k);
    return {(k == 0), ((k % W) == W - 1), (k == NPIX - 1), 8'd40};
  endfunction

  // Datapath stand-in: emits one output beat per input beat once stubLag beats are buffered, up to stubLimit
  always @(posedge clk) begin
    if (stubClear) begin
      stubIn  = 0;
      stubOut = 0;
      stubValid <= 1'b0;
    end else begin
      stubValid <= 1'b0;
      if (dpValid) begin
        stubMem[stubIn[7:0]] = min3(dpR, dpG, dpB);
        stubBack = stubIn - stubLag;
        if (stubBack >= 0 && stubOut < stubLimit) begin
          stubValid <= 1'b1;
          stubDark  <= stubMem[stubBack[7:0]];
          stubOut++;
        end
        stubIn++;
      end
    end
  end

  // Monitor on the falling edge: logs tagged beats, datapath pixels, pads and done/err pulses
  always @(negedge clk) begin
    if (mValid) beatLog.push_back({mSof, mEol, mEof, mDark});
    if (dpValid) begin
      if ({dpR, dpG, dpB} == 24'hFFFFFF) padCnt++;
      else pixLog.push_back({dpR, dpG, dpB});
    end
    if (done) doneCnt++;
    if (err) errCnt++;
    if (err && !done) errNoDone++;
  end

  task automatic checkOutput(input string tag, input int observed, input int expected);
    testsRun++;
    assert (observed === expected)
    else begin
      failCount++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  task automatic clearLogs();
    beatLog.delete();
    pixLog.delete();
    padCnt    = 0;
    doneCnt   = 0;
    errCnt    = 0;
    errNoDone = 0;
  endtask

  task automatic startFrame(input bit hold);
    stubClear = 1'b1;
    clearLogs();
    start = 1'b1;
    @(posedge clk); #1;
    stubClear = 1'b0;
    if (!hold) start = 1'b0;
  endtask

  task automatic applyStimulus(input int nPix, input bit toggle, input bit varyG);
    for (int i = 0; i < nPix; i++) begin
      int guard;
      bit ok;
      sValid = 1'b1;
      sR     = 8'd40;
      sG     = varyG ? 8'(50 + i) : 8'd50;
      sB     = 8'd60;
      guard  = 0;
      ok     = 1'b0;
      while (!ok && guard < 50) begin
        ok = sReady;
        @(posedge clk); #1;
        guard++;
      end
      if (!ok) checkOutput($sformatf("acceptTimeout%0d", i), 0, 1);
      if (toggle) begin
        sValid = 1'b0;
        @(posedge clk); #1;
      end
    end
    sValid = 1'b0;
  endtask

  task automatic waitDone();
    int n;
    n = 0;
    do begin
      @(negedge clk); #1;
      n++;
    end while (!done && n < 400);
    checkOutput("doneSeen", int'(done), 1);
  endtask

  task automatic checkFrame(input string tag, input int expBeats, input int expPads, input int expErr, input bit varyG);
    int n;
    n = beatLog.size();
    checkOutput({tag, ".beatCount"}, n, expBeats);
    for (int k = 0; k < n && k < expBeats; k++)
      checkOutput($sformatf("%s.beat%0d", tag, k), int'(beatLog[k]), int'(expTag(k)));
    checkOutput({tag, ".padCount"}, padCnt, expPads);
    checkOutput({tag, ".pixCount"}, pixLog.size(), NPIX);
    for (int k = 0; k < pixLog.size() && k < NPIX; k++)
      checkOutput($sformatf("%s.pix%0d", tag, k), int'(pixLog[k]),
                  int'({8'd40, (varyG ? 8'(50 + k) : 8'd50), 8'd60}));
    checkOutput({tag, ".doneCount"}, doneCnt, 1);
    checkOutput({tag, ".errCount"}, errCnt, expErr);
    checkOutput({tag, ".errWithoutDone"}, errNoDone, 0);
  endtask

  task automatic finishFrame(input string tag, input int expBeats, input int expPads, input int expErr, input bit varyG);
    waitDone();
    @(negedge clk); #1;
    checkOutput({tag, ".idleAfterDone"}, int'(busy), 0);
    repeat (3) begin
      @(negedge clk); #1;
    end
    checkFrame(tag, expBeats, expPads, expErr, varyG);
  endtask

  // Watchdog so a stuck run still terminates with a report
  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst    = 1'b1;
    start  = 1'b0;
    sValid = 1'b0;
    sR     = '0;
    sG     = '0;
    sB     = '0;

    // Reset held three cycles: every control output and data register at zero
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst.busy",    int'(busy),    0);
    checkOutput("rst.done",    int'(done),    0);
    checkOutput("rst.err",     int'(err),     0);
    checkOutput("rst.sReady",  int'(sReady),  0);
    checkOutput("rst.dpValid", int'(dpValid), 0);
    checkOutput("rst.mValid",  int'(mValid),  0);
    checkOutput("rst.dpR",     int'(dpR),     0);
    checkOutput("rst.mDark",   int'(mDark),   0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Back-to-back frame of (40,50,60): 48 tagged beats of 40, 38 pads before completion
    startFrame(1'b0);
    applyStimulus(NPIX, 1'b0, 1'b0);
    finishFrame("s2", NPIX, 38, 0, 1'b0);

    // Valid toggling 1,0,1,0 with a ramp on green so pixel order is visible on the datapath
    startFrame(1'b0);
    applyStimulus(NPIX, 1'b1, 1'b1);
    finishFrame("s3", NPIX, 38, 0, 1'b1);

    // Start held high: one frame, one done, a single idle cycle, then exactly one restart
    startFrame(1'b1);
    applyStimulus(NPIX, 1'b0, 1'b0);
    waitDone();
    checkOutput("s4.doneFrame1", doneCnt, 1);
    checkOutput("s4.beatsFrame1", beatLog.size(), NPIX);
    stubClear = 1'b1;
    clearLogs();
    @(negedge clk); #1;
    checkOutput("s4.idleBetween", int'(busy), 0);
    stubClear = 1'b0;
    @(negedge clk); #1;
    checkOutput("s4.restart", int'(busy), 1);
    start = 1'b0;
    applyStimulus(NPIX, 1'b0, 1'b0);
    finishFrame("s4", NPIX, 38, 0, 1'b0);

    // Short datapath: only 30 beats return, so the 40-pad cap fires done and err together
    stubLimit = 30;
    startFrame(1'b0);
    applyStimulus(NPIX, 1'b0, 1'b0);
    finishFrame("s5", 30, 40, 1, 1'b0);
    stubLimit = 1000;

    // Reset after 20 accepted pixels, then stale datapath beats must be dropped
    startFrame(1'b0);
    applyStimulus(20, 1'b0, 1'b0);
    sValid = 1'b1;
    rst    = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checkOutput("s6.busyAfterRst",    int'(busy),    0);
    checkOutput("s6.sReadyAfterRst",  int'(sReady),  0);
    checkOutput("s6.dpValidAfterRst", int'(dpValid), 0);
    sValid = 1'b0;
    clearLogs();
    manual   = 1'b1;
    manValid = 1'b1;
    repeat (4) begin
      @(posedge clk); #1;
    end
    manValid = 1'b0;
    manual   = 1'b0;
    @(negedge clk); #1;
    @(negedge clk); #1;
    checkOutput("s6.staleDropped", beatLog.size(), 0);
    checkOutput("s6.noDone", doneCnt, 0);

    startFrame(1'b0);
    applyStimulus(NPIX, 1'b0, 1'b0);
    finishFrame("s6", NPIX, 38, 0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end

endmodule
